stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have ports: clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have inputs pause, sel and adj, each 1 bit: debounced button or switch levels.
REQ-004 SHALL have inputs onehz_clk and twohz_clk, each 1 bit: divided-clock levels, synchronous to clk.
REQ-005 SHALL have inputs sec_max and min_max, each 1 bit: high when the counter's seconds==59 or minutes==59.
REQ-006 SHALL have outputs sec_inc, sec_clr, min_inc and min_clr, each 1 bit: single-cycle counter commands.
REQ-007 SHALL have outputs blink_min and blink_sec, each 1 bit: display blink enables for the field being adjusted.
REQ-008 SHALL have output mode, 2 bits: current state encoding.
REQ-009 SHALL have output paused, 1 bit: the paused flag.

Function
REQ-010 SHALL detect a rising edge on pause, onehz_clk and twohz_clk as: input==1 at this clk edge and ==0 at the previous clk edge.
REQ-011 SHALL implement states RUN=0, PAUSE=1, ADJ_MIN=2, ADJ_SEC=3.
- adj==1 and sel==0 -> ADJ_MIN.
- adj==1 and sel==1 -> ADJ_SEC.
- adj==0 -> PAUSE if paused==1, else RUN.
REQ-012 SHALL toggle paused on each pause rising edge in any state, including adjust states; paused persists across adjust.
REQ-013 SHALL, in RUN on a onehz_clk edge:
- sec_max==0 -> sec_inc.
- sec_max==1 -> sec_clr, plus min_inc if min_max==0, else min_clr (59:59 wraps to 00:00).
REQ-014 SHALL, in ADJ_SEC on a twohz_clk edge, assert sec_clr if sec_max==1, else sec_inc; never touch minutes.
REQ-015 SHALL, in ADJ_MIN on a twohz_clk edge, assert min_clr if min_max==1, else min_inc; never touch seconds.
REQ-016 SHALL ignore all tick edges in PAUSE, and SHALL ignore onehz_clk edges in adjust states.
REQ-017 SHALL register all command outputs: a command is high exactly one clk cycle, loaded at the same clk edge at which the tick edge is detected.
REQ-018 SHALL never assert inc and clr of the same field in the same cycle.
REQ-019 SHALL hold every command output 0 in all cycles without a qualifying tick edge.
REQ-020 SHALL evaluate a tick edge against the registered state before that edge's update when a tick edge coincides with a pause edge or an adj/sel change; the new state takes effect next cycle.
REQ-021 SHALL drive blink_min=1 only in ADJ_MIN and blink_sec=1 only in ADJ_SEC, registered with mode.
REQ-022 SHALL follow sel changes while adj==1 on the next clk edge (ADJ_MIN<->ADJ_SEC directly).

Reset
REQ-023 SHALL, while rst==1, force:
- mode=RUN, paused=0.
- All command outputs and blink outputs 0.
- Tick edge registers 0.
- pause edge register 1, so a pause held through reset release does not toggle.
REQ-024 SHALL, on rst assertion mid-operation (including mid-pulse), clear outputs immediately without waiting for clk.
REQ-025 SHALL generate no command in the first clk cycle after reset release unless a tick edge is detected then.

Structure
REQ-026 SHALL place the following in shared package stopwatch_pkg:
- State encodings RUN/PAUSE/ADJ_MIN/ADJ_SEC.
- The 2-bit mode width.
- Constant MAX_COUNT=59.
REQ-027 SHALL use one sub-module rise_edge (reset value parameterised), instantiated three times (pause, onehz_clk, twohz_clk); FSM and command logic stay in stopwatch_ctrl.

Verification
REQ-028 SHALL cover wrap: RUN, sec_max=1, min_max=1, onehz_clk edge -> next cycle sec_clr=1, min_clr=1, sec_inc=min_inc=0, pulses last 1 cycle.
REQ-029 SHALL cover pause toggle: pause 0->1 -> paused=1, mode=PAUSE, three onehz_clk edges produce no commands; second pause edge -> mode=RUN, next onehz_clk edge -> sec_inc.
REQ-030 SHALL cover adjust: adj=1, sel=0, four twohz_clk edges with min_max=0 -> four min_inc pulses, zero sec_* pulses, blink_min=1; sel->1 -> blink_sec=1 next cycle.
REQ-031 SHALL cover adjust wrap: ADJ_SEC, sec_max=1, twohz_clk edge -> sec_clr only; no min_* pulse.
REQ-032 SHALL cover simultaneous events: pause edge coinciding with a onehz_clk edge in RUN -> sec_inc still issued, mode=PAUSE next cycle.
REQ-033 SHALL cover async reset: rst asserted between clk edges while sec_inc=1 -> sec_inc=0 immediately; pause held high across release -> paused stays 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch control block.
//   MODE_W    : width of the mode/state encoding
//   MAX_COUNT : terminal value of the seconds and minutes counters
//   mode_e    : controller states as seen on the mode output
//   cmd_t     : one-cycle counter command bundle
package stopwatch_pkg;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MAX_COUNT = 59;

  typedef enum logic [MODE_W-1:0] {
    RUN     = 2'd0,
    PAUSE   = 2'd1,
    ADJ_MIN = 2'd2,
    ADJ_SEC = 2'd3
  } mode_e;

  typedef struct packed {
    logic sec_inc;
    logic sec_clr;
    logic min_inc;
    logic min_clr;
  } cmd_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its environment.
//   inputs to the controller : pause, sel, adj, onehz_clk, twohz_clk,
//                              sec_max, min_max
//   outputs of the controller: sec_inc, sec_clr, min_inc, min_clr,
//                              blink_min, blink_sec, mode, paused
// master = environment side (buttons, dividers, counter), slave = controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic              pause;
  logic              sel;
  logic              adj;
  logic              onehz_clk;
  logic              twohz_clk;
  logic              sec_max;
  logic              min_max;
  logic              sec_inc;
  logic              sec_clr;
  logic              min_inc;
  logic              min_clr;
  logic              blink_min;
  logic              blink_sec;
  logic [MODE_W-1:0] mode;
  logic              paused;

  modport master (
    output pause, sel, adj, onehz_clk, twohz_clk, sec_max, min_max,
    input  sec_inc, sec_clr, min_inc, min_clr, blink_min, blink_sec, mode, paused
  );

  modport slave (
    input  pause, sel, adj, onehz_clk, twohz_clk, sec_max, min_max,
    output sec_inc, sec_clr, min_inc, min_clr, blink_min, blink_sec, mode, paused
  );

endinterface

// File: rtl/rise_edge.sv
// Rising-edge detector for a level synchronous to clk.
//   clk, rst : clock and asynchronous active-high reset
//   d        : sampled level
//   rise_c   : combinational, high when d==1 now and d==0 at the previous edge
// RST_VAL sets the remembered "previous" level out of reset; 1 suppresses an
// edge for a level that is already high when reset releases.
module rise_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= RST_VAL;
    else     prev <= d;
  end

  assign rise_c = d & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/adjust state machine issuing single-cycle
// increment/clear commands to an external MM:SS counter.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : stopwatch_ctrl_if.slave (buttons, tick levels, counter maxima in;
//              counter commands, blink enables, mode and paused flag out)
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  logic  pause_rise;
  logic  onehz_rise;
  logic  twohz_rise;

  mode_e state, state_n;
  logic  paused_q, paused_n;
  cmd_t  cmd_q, cmd_n;
  logic  blink_min_q, blink_min_n;
  logic  blink_sec_q, blink_sec_n;

  // Pause starts "high" so a button held through reset release is not an edge.
  rise_edge #(.RST_VAL(1'b1)) u_pause_edge (
    .clk(clk), .rst(rst), .d(bus.pause), .rise_c(pause_rise)
  );

  rise_edge #(.RST_VAL(1'b0)) u_onehz_edge (
    .clk(clk), .rst(rst), .d(bus.onehz_clk), .rise_c(onehz_rise)
  );

  rise_edge #(.RST_VAL(1'b0)) u_twohz_edge (
    .clk(clk), .rst(rst), .d(bus.twohz_clk), .rise_c(twohz_rise)
  );

  // State, paused flag, commands and blink enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      paused_q    <= 1'b0;
      cmd_q       <= '0;
      blink_min_q <= 1'b0;
      blink_sec_q <= 1'b0;
    end else begin
      state       <= state_n;
      paused_q    <= paused_n;
      cmd_q       <= cmd_n;
      blink_min_q <= blink_min_n;
      blink_sec_q <= blink_sec_n;
    end
  end

  // Next state from the switches; commands from the current (pre-update) state.
  always_comb begin
    state_n     = state;
    paused_n    = paused_q;
    cmd_n       = '0;
    blink_min_n = 1'b0;
    blink_sec_n = 1'b0;

    if (pause_rise) paused_n = ~paused_q;

    if (bus.adj) state_n = bus.sel ? ADJ_SEC : ADJ_MIN;
    else         state_n = paused_n ? PAUSE : RUN;

    blink_min_n = (state_n == ADJ_MIN);
    blink_sec_n = (state_n == ADJ_SEC);

    case (state)
      RUN: begin
        if (onehz_rise) begin
          if (bus.sec_max) begin
            cmd_n.sec_clr = 1'b1;
            if (bus.min_max) cmd_n.min_clr = 1'b1;
            else             cmd_n.min_inc = 1'b1;
          end else begin
            cmd_n.sec_inc = 1'b1;
          end
        end
      end
      ADJ_SEC: begin
        if (twohz_rise) begin
          if (bus.sec_max) cmd_n.sec_clr = 1'b1;
          else             cmd_n.sec_inc = 1'b1;
        end
      end
      ADJ_MIN: begin
        if (twohz_rise) begin
          if (bus.min_max) cmd_n.min_clr = 1'b1;
          else             cmd_n.min_inc = 1'b1;
        end
      end
      PAUSE:   ;
      default: ;
    endcase
  end

  assign bus.sec_inc   = cmd_q.sec_inc;
  assign bus.sec_clr   = cmd_q.sec_clr;
  assign bus.min_inc   = cmd_q.min_inc;
  assign bus.min_clr   = cmd_q.min_clr;
  assign bus.blink_min = blink_min_q;
  assign bus.blink_sec = blink_sec_q;
  assign bus.mode      = state;
  assign bus.paused    = paused_q;

endmodule
